mem_port_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arb_select.sv | 31 +++
 rtl/mem_port_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings and default widths for the unified-memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        ACK   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Arbitration decision between fetch and data requesters.
// Data wins unless fetch is waiting and data has already taken a full burst.
module mem_arb_select #(
    parameter int CNT_W = 3
) (
    input  logic             i_req,
    input  logic             d_req,
    input  logic             burst_full,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             grant_i,
    output logic             grant_d,
    output logic [CNT_W-1:0] burst_cnt_next
);

    // Pick a winner and compute the burst counter that goes with that grant.
    always_comb begin
        grant_d        = d_req && !(i_req && burst_full);
        grant_i        = !grant_d && i_req;
        burst_cnt_next = burst_cnt;
        if (grant_d) begin
            if (!i_req) begin
                burst_cnt_next = '0;
            end else if (!burst_full) begin
                burst_cnt_next = burst_cnt + CNT_W'(1);
            end
        end else if (grant_i) begin
            burst_cnt_next = '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch port and the data port.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | arbitrate between i_req and d_req, latch winner onto m_*
//   GNT_I | fetch access in flight, m_req held until m_ack
//   GNT_D | data access in flight, m_req held until m_ack
//   ACK   | one-cycle completion pulse to the owner, requests ignored
//
// Holding off arbitration during ACK gives the requester one cycle to drop
// or change its request, so a held request is never served twice.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = DEF_AW,
    parameter int DW          = DEF_DW,
    parameter int MAX_D_BURST = 4,
    parameter int CNT_W       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack
);

    arb_state_t       state;
    owner_t           owner;
    logic [CNT_W-1:0] burst_cnt;
    logic [CNT_W-1:0] burst_cnt_next;
    logic             burst_full;
    logic             grant_i;
    logic             grant_d;

    assign burst_full = (burst_cnt == CNT_W'(MAX_D_BURST));

    mem_arb_select #(
        .CNT_W (CNT_W)
    ) u_select (
        .i_req          (i_req),
        .d_req          (d_req),
        .burst_full     (burst_full),
        .burst_cnt      (burst_cnt),
        .grant_i        (grant_i),
        .grant_d        (grant_d),
        .burst_cnt_next (burst_cnt_next)
    );

    // Arbitration FSM with all memory-side and requester-side outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            burst_cnt <= '0;
            m_req     <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            i_ack     <= 1'b0;
            d_ack     <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            case (state)
                IDLE: begin
                    burst_cnt <= burst_cnt_next;
                    if (grant_d) begin
                        state   <= GNT_D;
                        owner   <= OWN_D;
                        m_req   <= 1'b1;
                        m_we    <= d_we;
                        m_addr  <= d_addr;
                        m_wdata <= d_wdata;
                    end else if (grant_i) begin
                        state  <= GNT_I;
                        owner  <= OWN_I;
                        m_req  <= 1'b1;
                        m_we   <= 1'b0;
                        m_addr <= i_addr;
                    end else begin
                        m_req <= 1'b0;
                    end
                end
                GNT_I, GNT_D: begin
                    if (m_ack) begin
                        m_req <= 1'b0;
                        m_we  <= 1'b0;
                        state <= ACK;
                        if (owner == OWN_I) begin
                            i_rdata <= m_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            // m_we is the latched copy of d_we for this access
                            if (!m_we) begin
                                d_rdata <= m_rdata;
                            end
                            d_ack <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: requester and memory models run in one
// loop after each rising edge; the main sequence runs on falling edges.
module tb_mem_port_arbiter;

    localparam int MAXB = 4;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } dtx_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_ack, d_req, d_we, d_ack;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;

    logic        s_i_req, s_d_req, s_full, s_gi, s_gd;
    logic [2:0]  s_cnt, s_next;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_BURST(MAXB), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack)
    );

    mem_arb_select #(.CNT_W(3)) sel_u (
        .i_req(s_i_req), .d_req(s_d_req), .burst_full(s_full), .burst_cnt(s_cnt),
        .grant_i(s_gi), .grant_d(s_gd), .burst_cnt_next(s_next)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tb_check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // bench memory contents: written words, otherwise a function of the address
    logic [31:0] mem_w [logic [31:0]];

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (mem_w.exists(a)) return mem_w[a];
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    logic [31:0] i_jobs [$];
    dtx_t        d_jobs [$];
    logic [31:0] i_exp_q [$];
    dtx_t        d_exp_q [$];
    logic        order_q [$];      // 0 = fetch, 1 = data

    int          lat = 1;
    logic        chk_lat = 1'b0;
    logic        late_drop = 1'b0;
    logic        stray_req = 1'b0;
    int          ack_i_cnt = 0, ack_d_cnt = 0, late_ack_cnt = 0;
    int          cyc = 0;
    logic        i_busy = 1'b0, d_busy = 1'b0;
    logic [31:0] i_cur_addr;
    int          i_issue_cyc, d_issue_cyc;
    logic [31:0] last_d_rdata = '0;

    logic        mem_busy = 1'b0;
    int          mem_rem, last_m_cycles;
    logic [31:0] last_m_addr, last_m_wdata;
    logic        last_m_we, m_unstable;
    logic        prev_i_ack = 1'b0, prev_d_ack = 1'b0;

    // requesters, scoreboard checks and memory responder, once per cycle
    initial begin
        dtx_t dj;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (rst) begin
                i_busy = 0; d_busy = 0; i_req = 0; d_req = 0;
                i_exp_q.delete(); d_exp_q.delete(); order_q.delete();
                last_d_rdata = '0;
            end else begin
                if (prev_i_ack) tb_check("i_ack_pulse", i_ack, 0);
                if (prev_d_ack) tb_check("d_ack_pulse", d_ack, 0);
                if (i_ack || d_ack) tb_check("ack_excl", i_ack & d_ack, 0);
                if (i_ack) begin
                    ack_i_cnt++;
                    if (i_exp_q.size() == 0) tb_check("i_ack_unexpected", 1, 0);
                    else tb_check("i_rdata", i_rdata, i_exp_q.pop_front());
                    tb_check("i_m_addr", last_m_addr, i_cur_addr);
                    tb_check("i_m_we", last_m_we, 0);
                    tb_check("i_mreq_cycles", last_m_cycles, lat);
                    tb_check("i_m_stable", m_unstable, 0);
                    if (order_q.size() != 0) tb_check("grant_order", 0, order_q.pop_front());
                    if (chk_lat) tb_check("i_latency", cyc - i_issue_cyc, lat + 1);
                    i_busy = 0;
                end
                if (d_ack) begin
                    ack_d_cnt++;
                    if (d_exp_q.size() == 0) tb_check("d_ack_unexpected", 1, 0);
                    else begin
                        dj = d_exp_q.pop_front();
                        if (dj.we) begin
                            tb_check("d_rdata_hold", d_rdata, last_d_rdata);
                            tb_check("d_m_wdata", last_m_wdata, dj.wdata);
                        end else begin
                            tb_check("d_rdata", d_rdata, dj.rdata);
                            last_d_rdata = dj.rdata;
                        end
                        tb_check("d_m_addr", last_m_addr, dj.addr);
                        tb_check("d_m_we", last_m_we, dj.we);
                    end
                    tb_check("d_mreq_cycles", last_m_cycles, lat);
                    tb_check("d_m_stable", m_unstable, 0);
                    if (order_q.size() != 0) tb_check("grant_order", 1, order_q.pop_front());
                    if (chk_lat) tb_check("d_latency", cyc - d_issue_cyc, lat + 1);
                    d_busy = 0;
                end
                if (!i_busy) begin
                    if (i_jobs.size() != 0) begin
                        i_cur_addr = i_jobs.pop_front();
                        i_req = 1; i_addr = i_cur_addr; i_busy = 1; i_issue_cyc = cyc;
                        i_exp_q.push_back(model_rd(i_cur_addr));
                    end else if (!(late_drop && i_ack)) begin
                        i_req = 0;
                    end
                end
                if (!d_busy) begin
                    if (d_jobs.size() != 0) begin
                        dj = d_jobs.pop_front();
                        dj.rdata = model_rd(dj.addr);
                        d_req = 1; d_we = dj.we; d_addr = dj.addr; d_wdata = dj.wdata;
                        d_busy = 1; d_issue_cyc = cyc;
                        d_exp_q.push_back(dj);
                    end else begin
                        d_req = 0;
                    end
                end
            end
            prev_i_ack = i_ack && !rst;
            prev_d_ack = d_ack && !rst;
            if (m_ack) begin
                m_ack = 0; mem_busy = 0;
            end else begin
                if (!mem_busy && m_req && !rst) begin
                    mem_busy = 1; mem_rem = lat; last_m_cycles = 0; m_unstable = 0;
                    last_m_addr = m_addr; last_m_we = m_we; last_m_wdata = m_wdata;
                end
                if (mem_busy) begin
                    if (m_req) begin
                        last_m_cycles++;
                        if (m_addr !== last_m_addr || m_we !== last_m_we || m_wdata !== last_m_wdata)
                            m_unstable = 1;
                    end
                    mem_rem--;
                    if (mem_rem == 0) begin
                        m_ack = 1;
                        if (!m_req) late_ack_cnt++;
                        if (last_m_we) mem_w[last_m_addr] = last_m_wdata;
                        else m_rdata = model_rd(last_m_addr);
                    end
                end else if (stray_req) begin
                    m_ack = 1; m_rdata = 32'hBAD0_BAD0; stray_req = 0;
                end
            end
        end
    end

    task automatic wait_done(input int max_cyc, input string tag);
        int n = 0;
        while ((i_jobs.size() != 0 || d_jobs.size() != 0 || i_busy || d_busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        tb_check({tag, "_done"}, (i_jobs.size() != 0 || d_jobs.size() != 0 || i_busy || d_busy), 0);
        repeat (2) @(negedge clk);
    endtask

    function automatic dtx_t mk_d(input logic we, input logic [31:0] a, input logic [31:0] w);
        dtx_t t;
        t.we = we; t.addr = a; t.wdata = w; t.rdata = '0;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          snap_i, snap_d, n;
        logic [31:0] snap_ird, snap_drd;
        logic        e_gi, e_gd;
        logic [2:0]  e_next;

        // selector on its own: every request pattern against every counter value
        for (int c = 0; c <= MAXB; c++) begin
            for (int p = 0; p < 4; p++) begin
                s_i_req = p[0]; s_d_req = p[1]; s_cnt = 3'(c); s_full = (c == MAXB);
                #1;
                e_gd   = s_d_req && !(s_i_req && c == MAXB);
                e_gi   = s_i_req && !e_gd;
                e_next = 3'(c);
                if (e_gd) e_next = s_i_req ? 3'(c + 1) : 3'd0;
                else if (e_gi) e_next = 3'd0;
                tb_check($sformatf("sel_c%0d_p%0d", c, p), {s_gi, s_gd, s_next}, {e_gi, e_gd, e_next});
            end
        end

        mem_w[32'h10] = 32'hDEAD_BEEF;
        rst = 1;
        repeat (3) @(negedge clk);
        tb_check("rst_m_req", m_req, 0);
        tb_check("rst_m_we", m_we, 0);
        tb_check("rst_m_addr", m_addr, 0);
        tb_check("rst_m_wdata", m_wdata, 0);
        tb_check("rst_acks", {i_ack, d_ack}, 0);
        tb_check("rst_i_rdata", i_rdata, 0);
        tb_check("rst_d_rdata", d_rdata, 0);
        rst = 0;
        @(negedge clk);

        // single fetch, memory answers in the first grant cycle
        chk_lat = 1; lat = 1;
        i_jobs.push_back(32'h10);
        wait_done(50, "fetch1");
        tb_check("fetch1_no_dack", ack_d_cnt, 0);
        tb_check("fetch1_iack_cnt", ack_i_cnt, 1);
        tb_check("fetch1_rdata", i_rdata, 32'hDEAD_BEEF);

        // single store with three cycles of memory latency
        lat = 3;
        d_jobs.push_back(mk_d(1, 32'h40, 32'h1234));
        wait_done(50, "store1");
        tb_check("store1_dack_cnt", ack_d_cnt, 1);
        tb_check("store1_d_rdata", d_rdata, 0);

        // both requesters saturated: four data grants, then one fetch, twice
        chk_lat = 0; lat = 2;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < MAXB; k++) order_q.push_back(1'b1);
            order_q.push_back(1'b0);
        end
        i_jobs.push_back(32'h100);
        i_jobs.push_back(32'h104);
        for (int k = 0; k < 8; k++)
            d_jobs.push_back(mk_d(k[0], 32'h200 + 32'(4 * k), 32'hA000 + 32'(k)));
        wait_done(400, "burst");
        tb_check("burst_order_left", order_q.size(), 0);

        // simultaneous rise with an empty burst count: data first, then fetch
        lat = 1;
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        i_jobs.push_back(32'h180);
        d_jobs.push_back(mk_d(0, 32'h280, 32'h0));
        wait_done(50, "simul");
        tb_check("simul_order_left", order_q.size(), 0);

        // m_ack while idle must change nothing
        snap_i = ack_i_cnt; snap_d = ack_d_cnt; snap_ird = i_rdata; snap_drd = d_rdata;
        stray_req = 1;
        repeat (5) @(negedge clk);
        tb_check("stray_acks", {32'(ack_i_cnt - snap_i), 32'(ack_d_cnt - snap_d)}, 0);
        tb_check("stray_m_req", m_req, 0);
        tb_check("stray_i_rdata", i_rdata, snap_ird);
        tb_check("stray_d_rdata", d_rdata, snap_drd);

        // request still high during the ACK cycle is served only once
        late_drop = 1;
        snap_i = ack_i_cnt;
        i_jobs.push_back(32'h1C0);
        wait_done(50, "late");
        repeat (6) @(negedge clk);
        tb_check("late_single_ack", ack_i_cnt - snap_i, 1);
        tb_check("late_m_req", m_req, 0);
        late_drop = 0;

        // reset while a data read is in flight; its m_ack lands after reset
        lat = 6;
        snap_i = ack_i_cnt; snap_d = ack_d_cnt; n = 0;
        d_jobs.push_back(mk_d(0, 32'h300, 32'h0));
        while (!m_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        tb_check("rstmid_m_req_seen", m_req, 1);
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (10) @(negedge clk);
        tb_check("rstmid_late_mack", late_ack_cnt > 0, 1);
        tb_check("rstmid_acks", {32'(ack_i_cnt - snap_i), 32'(ack_d_cnt - snap_d)}, 0);
        tb_check("rstmid_m_req", m_req, 0);
        tb_check("rstmid_m_addr", m_addr, 0);
        tb_check("rstmid_m_we", m_we, 0);
        tb_check("rstmid_m_wdata", m_wdata, 0);
        tb_check("rstmid_i_rdata", i_rdata, 0);
        tb_check("rstmid_d_rdata", d_rdata, 0);

        // normal service resumes after reset
        lat = 1;
        d_jobs.push_back(mk_d(0, 32'h300, 32'h0));
        wait_done(50, "after_rst");
        tb_check("after_rst_dack", ack_d_cnt - snap_d, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
